// File: rtl/knock_pkg.sv
// Shared types and constants for the knock pattern detector.
package knock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_HOLDOFF = 2'd2
  } knock_state_e;

  localparam int unsigned TMR_W   = 13;
  localparam int unsigned TMR_MAX = (1 << TMR_W) - 1;

  localparam int unsigned        CNT_W   = 3;
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  localparam int unsigned LED_LEN = 100;
  localparam int unsigned LED_W   = 7;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic bit timer_param_ok(input int unsigned v);
    return (v >= 1) && (v <= TMR_MAX);
  endfunction

endpackage

// File: rtl/knock_debounce.sv
// Two-flop synchronizer followed by a stable-time debouncer for the raw knock sensor.
module knock_debounce
  import knock_pkg::*;
#(
  parameter int unsigned DEB_MS = 8
) (
  input  logic CLK1K,
  input  logic RSTN,
  input  logic knock_i,
  output logic level_o
);

  localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'(DEB_MS - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= knock_i;
      sync2_q <= sync1_q;
    end
  end

  // The count only advances while the synchronized input disagrees with the
  // held level; it flips after DEB_MS consecutive disagreeing cycles.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

  always_ff @(posedge CLK1K) begin
    assert (timer_param_ok(DEB_MS))
      else $error("knock_debounce: DEB_MS=%0d outside 1..%0d", DEB_MS, TMR_MAX);
  end

endmodule

// File: rtl/knock_pattern_detect.sv
// Knock pattern detector: counts debounced knocks in a window and pulses ALARM.
// Optional KNOCK_LED stretch output is built when KNOCK_LED_EN is defined.
module knock_pattern_detect
  import knock_pkg::*;
#(
  parameter int unsigned DEB_MS       = 8,
  parameter int unsigned WINDOW_MS    = 1000,
  parameter int unsigned KNOCK_THRESH = 3,
  parameter int unsigned HOLDOFF_MS   = 4200
) (
  input  logic             CLK1K,
  input  logic             RSTN,
  input  logic             KNOCK_IN,
  output logic             ALARM,
  output logic [CNT_W-1:0] KNOCK_CNT,
  output logic             BUSY
`ifdef KNOCK_LED_EN
  ,
  output logic             KNOCK_LED
`endif
);

  localparam logic [TMR_W-1:0] WIN_LAST  = TMR_W'(WINDOW_MS - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF_MS - 1);

  logic             deb_level;
  logic             level_prev_q;
  logic             knock_evt;

  knock_state_e     state_q;
  knock_state_e     state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic             alarm_q;
  logic             alarm_d;

  knock_debounce #(
    .DEB_MS (DEB_MS)
  ) u_debounce (
    .CLK1K   (CLK1K),
    .RSTN    (RSTN),
    .knock_i (KNOCK_IN),
    .level_o (deb_level)
  );

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= deb_level;
    end
  end

  assign knock_evt = deb_level & ~level_prev_q;

  // The window and holdoff phases never overlap, so they share one timer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    alarm_d = 1'b0;
    cnt_inc = knock_evt ? sat_inc(cnt_q) : cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (knock_evt) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_W'(1);
          tmr_d   = '0;
        end
      end
      ST_COUNT: begin
        cnt_d = cnt_inc;
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == WIN_LAST) begin
          cnt_d = '0;
          tmr_d = '0;
          if (32'(cnt_inc) >= KNOCK_THRESH) begin
            alarm_d = 1'b1;
            state_d = ST_HOLDOFF;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLDOFF: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == HOLD_LAST) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      alarm_q <= alarm_d;
    end
  end

  assign ALARM     = alarm_q;
  assign KNOCK_CNT = cnt_q;
  assign BUSY      = (state_q != ST_IDLE);

`ifdef KNOCK_LED_EN
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_d;

  always_comb begin
    led_d = led_q;
    if (knock_evt) begin
      led_d = LED_W'(LED_LEN);
    end else if (led_q != '0) begin
      led_d = led_q - 1'b1;
    end
  end

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign KNOCK_LED = (led_q != '0);
`endif

  always_ff @(posedge CLK1K) begin
    assert (timer_param_ok(WINDOW_MS))
      else $error("knock_pattern_detect: WINDOW_MS=%0d outside 1..%0d", WINDOW_MS, TMR_MAX);
    assert (timer_param_ok(HOLDOFF_MS))
      else $error("knock_pattern_detect: HOLDOFF_MS=%0d outside 1..%0d", HOLDOFF_MS, TMR_MAX);
    assert (KNOCK_THRESH <= TMR_MAX)
      else $error("knock_pattern_detect: KNOCK_THRESH=%0d above %0d", KNOCK_THRESH, TMR_MAX);
    if (RSTN) begin
      assert (!(alarm_q && alarm_d))
        else $error("knock_pattern_detect: ALARM asserted on consecutive cycles");
    end
  end

endmodule

// File: doc/knock_pattern_detect.md
KNOCK_PATTERN_DETECT -- requirements
Module: knock_pattern_detect

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEB_MS, 8, debounce stable time in CLK1K cycles.
- WINDOW_MS, 1000, knock-counting window in cycles.
- KNOCK_THRESH, 3, minimum knocks in a window that trigger an alarm.
- HOLDOFF_MS, 4200, re-arm lockout after an alarm; this exceeds the downstream buzzer burst.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning (clock and reset first).
- CLK1K, in, 1, 1 kHz system clock.
- RSTN, in, 1, reset; asynchronous, active-low.
- KNOCK_IN, in, 1, raw knock sensor; asynchronous and bouncy.
- ALARM, out, 1, single-cycle pulse consumed by the buzzer alarm stage.
- KNOCK_CNT, out, 3, knocks counted in the current window.
- BUSY, out, 1, high in COUNT or HOLDOFF.

Function
REQ-003 KNOCK_IN SHALL pass through a 2-flop synchronizer before any other use.
REQ-004 The debounced level SHALL change only after the synchronized input differs from it for DEB_MS consecutive cycles; any match restarts the count.
REQ-005 A knock event SHALL be a one-cycle pulse on each 0->1 transition of the debounced level.
- Latency from a clean KNOCK_IN rise to the event SHALL be 2+DEB_MS cycles.
REQ-006 The FSM SHALL have three states:
- IDLE: waiting for the first knock.
- COUNT: window open.
- HOLDOFF: lockout after an alarm.
REQ-007 IDLE + knock event: go to COUNT, KNOCK_CNT=1, window timer=0.
REQ-008 In COUNT, each knock event SHALL increment KNOCK_CNT, saturating at 7; the window timer SHALL increment every cycle.
REQ-009 When the window timer reaches WINDOW_MS-1:
- If KNOCK_CNT (including any knock in that same cycle) >= KNOCK_THRESH: ALARM=1 for exactly one cycle, go to HOLDOFF.
- Otherwise: go to IDLE.
- In both cases KNOCK_CNT clears on the following cycle.
REQ-010 HOLDOFF SHALL ignore knock events, count HOLDOFF_MS cycles, then return to IDLE.
REQ-011 ALARM SHALL never be asserted on two consecutive cycles or outside the COUNT->HOLDOFF transition.
REQ-012 Timers SHALL be 13 bits wide; parameters above 8191 are illegal and SHALL be flagged by a simulation-time assertion.

Reset
REQ-013 While RSTN is low:
- State=IDLE.
- ALARM=0, KNOCK_CNT=0, BUSY=0.
- All timers=0, synchronizer and debounced level=0.
REQ-014 Reset asserted mid-window or mid-holdoff SHALL abort immediately with no ALARM pulse.
- After release, the first valid knock SHALL need the full 2+DEB_MS latency.

Configuration
REQ-015 Macro KNOCK_LED_EN defined: an extra output KNOCK_LED (1 bit) SHALL pulse high for 100 cycles on each knock event.
- A new knock during the pulse SHALL restart the 100-cycle pulse.
- The pulse is a stretch only; it SHALL operate in HOLDOFF too.
REQ-016 Macro undefined: the KNOCK_LED port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-017 Package knock_pkg SHALL hold the state encoding constants (IDLE/COUNT/HOLDOFF), the timer width (13), and the LED stretch length (100).
REQ-018 Synchronizer plus debounce SHALL be a sub-module knock_debounce; its output is the debounced level, and edge detection stays in the parent.

Verification
REQ-019 Bench SHALL cover:
- 3 clean knocks at t=0, 200, 400 ms (each high 20 ms) -> one ALARM pulse at window end (about 1010 cycles after the first rise); BUSY high through HOLDOFF.
- 2 knocks within the window -> no ALARM; return to IDLE after 1000 cycles; KNOCK_CNT back to 0.
- A knock with 3-cycle bounce glitches (DEB_MS=8) -> exactly one event; a 5-cycle glitch alone -> no event.
- 3 knocks, then 4 more knocks during HOLDOFF -> a single ALARM; the HOLDOFF knocks are ignored; KNOCK_CNT stays 0.
- 9 knocks in one window -> KNOCK_CNT saturates at 7; one ALARM.
- RSTN pulsed low at cycle 500 of a window with 3 knocks -> no ALARM; all outputs 0.
- With KNOCK_LED_EN: 100-cycle LED stretch per knock.
